alu_seq: RTL and testbench
==========================

# alu_seq

Parametrised, multi-cycle signed arithmetic unit for the calculator datapath: add, subtract, Booth radix-2 multiply and restoring long division on WIDTH-bit two's-complement operands. It sits between the operand registers and the display mux. It replaces a single-strobe compute with a start/busy/done handshake, so multiply and divide iterate one bit per clock instead of unrolling.

## Interface
- WIDTH, 11: operand width in bits, signed two's complement, min 4.
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high; clears state and all outputs.
- computestrobe  in  1  start request, accepted only when busy=0.
- opcode  in  2  operation select: 00 add, 01 subtract, 10 multiply, 11 divide.
- regA  in  WIDTH  signed operand A (multiplicand / numerator).
- regB  in  WIDTH  signed operand B (multiplier / divisor).
- busy  out  1  high from the cycle after accept through the done cycle.
- done  out  1  one-cycle pulse; result fields are valid from this cycle.
- result  out  2*WIDTH  signed sum, difference, product or quotient.
- remainder  out  WIDTH  unsigned Euclidean remainder, 0 for non-divide.
- remain  out  1  1 iff the last operation was a divide with nonzero remainder.
- divzero  out  1  1 iff the last operation was a divide with regB=0.

## Operation
- FSM states: IDLE, MUL, DIV, FIN. A bit counter runs 0..WIDTH-1.
- Accept: in IDLE with computestrobe=1, latch regA, regB and opcode. Later input changes have no effect.
- Add/sub go IDLE→FIN. Operands are sign-extended to 2*WIDTH, so overflow is impossible.
- Multiply goes IDLE→MUL. P is initialised to {0, B, 0}.
  - Each cycle, P[1:0] selects the action: 01 adds A to the upper half, 10 subtracts A, otherwise no change.
  - P then shifts right arithmetically.
  - After WIDTH cycles the FSM goes to FIN with result = P[2*WIDTH:1].
  - The upper half is WIDTH+1 bits wide, so (-2^(W-1))² is exact.
- Divide with B≠0 goes IDLE→DIV.
  - Restoring division on |A| and |B|, MSB first, one quotient bit per cycle, WIDTH cycles.
  - FIN applies the correction: if A<0 and r≠0, then r := |B|-r and q := q+1.
  - q is negated iff sign(A)≠sign(B).
  - The result satisfies A = q·B + r with 0 ≤ r < |B|.
- Divide with B=0 goes IDLE→FIN directly: result=0, remainder=0, remain=0, divzero=1.
- FIN: assert done for one cycle, then return to IDLE.
- Outputs hold their values until the next done or reset. divzero and remain are cleared at the done of any other operation.
- computestrobe while busy=1 is ignored, not queued.

## Timing
- Reset values: busy=0, done=0, result=0, remainder=0, remain=0, divzero=0; state=IDLE.
- Accept happens at cycle 0.
- Add, subtract and divide-by-zero: done at cycle 1.
- Multiply and divide: done at cycle WIDTH+1 (cycle 12 for WIDTH=11).
- busy is high from cycle 1 through the done cycle inclusive.
- A new accept is possible on the cycle after done, giving back-to-back throughput of 1 operation per 2 or per WIDTH+2 cycles.
- Reset mid-operation takes effect on the next edge: state returns to IDLE, no done is emitted, and outputs are cleared.
- If reset and computestrobe are high together, reset wins.

## Structure
- Shared package alu_pkg holds:
  - opcode localparams OP_ADD, OP_SUB, OP_MUL, OP_DIV;
  - the FSM state encoding;
  - the 2*WIDTH result-width rule as a function.
- One sub-module, alu_div_fix: combinational Euclidean correction and sign restore. It is used in FIN and is unit-testable on its own.

## Test plan
- WIDTH=11, add 999+999 → result=1998, done at cycle 1. Subtract -999-999 → -1998.
- Multiply 999×-999 → result=-998001 at cycle 12, busy high cycles 1–12.
- Multiply -1024×-1024 → result=1048576 with no wrap.
- Divide -7/2 → result=-4, remainder=1, remain=1. Divide -7/-2 → result=4, remainder=1. Divide 6/3 → result=2, remainder=0, remain=0.
- Divide 5/0 → done at cycle 1, result=0, divzero=1. Next op 1+1 → divzero=0, result=2.
- Apply these together:
  - pulse computestrobe at cycle 5 of a multiply → ignored, and the original product is delivered;
  - assert reset at cycle 6 of a divide → no done, all outputs 0, next accept works.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the sequential calculator ALU: opcodes, FSM encoding
// and the result-width rule used by the top level and the divide fix-up.
package alu_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    MUL  = 2'b01,
    DIV  = 2'b10,
    FIN  = 2'b11
  } state_t;

  function automatic int res_w(input int w);
    return 2 * w;
  endfunction

endpackage

// File: rtl/alu_div_fix.sv
// Combinational Euclidean correction and sign restore for the restoring divider:
// turns |A|/|B| quotient and remainder into q, r with A = q*B + r, 0 <= r < |B|.
module alu_div_fix import alu_pkg::*; #(
  parameter int WIDTH = 11
) (
  input  logic [WIDTH-1:0]               q_mag_i,
  input  logic [WIDTH-1:0]               r_mag_i,
  input  logic [WIDTH-1:0]               b_mag_i,
  input  logic                           a_neg_i,
  input  logic                           b_neg_i,
  output logic signed [res_w(WIDTH)-1:0] q_o,
  output logic [WIDTH-1:0]               r_o
);

  localparam int RW = res_w(WIDTH);

  logic           adj;
  logic [WIDTH:0] q_adj;
  logic [RW-1:0]  q_ext;

  // A negative numerator with a nonzero magnitude remainder rounds the quotient away from zero.
  assign adj   = a_neg_i && (r_mag_i != '0);
  assign q_adj = {1'b0, q_mag_i} + {{WIDTH{1'b0}}, adj};
  assign q_ext = {{(RW - WIDTH - 1){1'b0}}, q_adj};
  assign q_o   = (a_neg_i ^ b_neg_i) ? -q_ext : q_ext;
  assign r_o   = adj ? (b_mag_i - r_mag_i) : r_mag_i;

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle signed ALU with start/busy/done handshake: single-cycle add/sub,
// Booth radix-2 multiply and restoring divide iterating one bit per clock.
module alu_seq import alu_pkg::*; #(
  parameter int WIDTH = 11
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           computestrobe,
  input  logic [1:0]                     opcode,
  input  logic signed [WIDTH-1:0]        regA,
  input  logic signed [WIDTH-1:0]        regB,
  output logic                           busy,
  output logic                           done,
  output logic signed [res_w(WIDTH)-1:0] result,
  output logic [WIDTH-1:0]               remainder,
  output logic                           remain,
  output logic                           divzero
);

  localparam int RW = res_w(WIDTH);
  localparam int PW = RW + 2;
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic signed [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic signed [PW-1:0]    p_q, p_d;
  logic [WIDTH-1:0]        rem_q, rem_d, quo_q, quo_d;
  logic signed [RW-1:0]    result_q, result_d;
  logic [WIDTH-1:0]        remainder_q, remainder_d;
  logic                    remain_q, remain_d, divzero_q, divzero_d;

  logic signed [RW-1:0]    a_sx, b_sx;
  logic signed [WIDTH:0]   a_ext, p_hi, p_hi_n;
  logic signed [PW-1:0]    p_step, p_next;
  logic [WIDTH:0]          rem_sh;
  logic                    rem_ge;
  logic [WIDTH-1:0]        b_mag, rem_next, quo_next, fix_r;
  logic signed [RW-1:0]    fix_q;

  function automatic logic [WIDTH-1:0] mag(input logic signed [WIDTH-1:0] v);
    logic [WIDTH-1:0] u;
    u = v;
    return v[WIDTH-1] ? (~u + 1'b1) : u;
  endfunction

  assign a_sx = {{WIDTH{regA[WIDTH-1]}}, regA};
  assign b_sx = {{WIDTH{regB[WIDTH-1]}}, regB};

  // Booth step: upper half is WIDTH+1 bits so subtracting the most negative A cannot wrap.
  assign a_ext = {a_q[WIDTH-1], a_q};
  assign p_hi  = p_q[PW-1 -: WIDTH+1];
  always_comb begin
    case (p_q[1:0])
      2'b01:   p_hi_n = p_hi + a_ext;
      2'b10:   p_hi_n = p_hi - a_ext;
      default: p_hi_n = p_hi;
    endcase
  end
  assign p_step = {p_hi_n, p_q[WIDTH:0]};
  assign p_next = p_step >>> 1;

  // Restoring divide step: quo_q holds the unconsumed dividend bits, quotient bits shift in at the LSB.
  assign b_mag    = mag(b_q);
  assign rem_sh   = {rem_q, quo_q[WIDTH-1]};
  assign rem_ge   = rem_sh >= {1'b0, b_mag};
  assign rem_next = rem_ge ? (rem_sh[WIDTH-1:0] - b_mag) : rem_sh[WIDTH-1:0];
  assign quo_next = {quo_q[WIDTH-2:0], rem_ge};

  alu_div_fix #(.WIDTH(WIDTH)) u_div_fix (
    .q_mag_i (quo_next),
    .r_mag_i (rem_next),
    .b_mag_i (b_mag),
    .a_neg_i (a_q[WIDTH-1]),
    .b_neg_i (b_q[WIDTH-1]),
    .q_o     (fix_q),
    .r_o     (fix_r)
  );

  // Result registers are only written on the edge that enters FIN, so they hold between operations.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    a_d         = a_q;
    b_d         = b_q;
    p_d         = p_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    result_d    = result_q;
    remainder_d = remainder_q;
    remain_d    = remain_q;
    divzero_d   = divzero_q;
    case (state_q)
      IDLE: begin
        if (computestrobe) begin
          a_d   = regA;
          b_d   = regB;
          cnt_d = '0;
          case (opcode)
            OP_ADD, OP_SUB: begin
              result_d    = (opcode == OP_ADD) ? (a_sx + b_sx) : (a_sx - b_sx);
              remainder_d = '0;
              remain_d    = 1'b0;
              divzero_d   = 1'b0;
              state_d     = FIN;
            end
            OP_MUL: begin
              p_d     = {{(WIDTH + 1){1'b0}}, regB, 1'b0};
              state_d = MUL;
            end
            default: begin
              if (regB == '0) begin
                result_d    = '0;
                remainder_d = '0;
                remain_d    = 1'b0;
                divzero_d   = 1'b1;
                state_d     = FIN;
              end else begin
                rem_d   = '0;
                quo_d   = mag(regA);
                state_d = DIV;
              end
            end
          endcase
        end
      end
      MUL: begin
        p_d   = p_next;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          result_d    = p_next[RW:1];
          remainder_d = '0;
          remain_d    = 1'b0;
          divzero_d   = 1'b0;
          state_d     = FIN;
        end
      end
      DIV: begin
        rem_d = rem_next;
        quo_d = quo_next;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          result_d    = fix_q;
          remainder_d = fix_r;
          remain_d    = (fix_r != '0);
          divzero_d   = 1'b0;
          state_d     = FIN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      result_q    <= '0;
      remainder_q <= '0;
      remain_q    <= 1'b0;
      divzero_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      result_q    <= result_d;
      remainder_q <= remainder_d;
      remain_q    <= remain_d;
      divzero_q   <= divzero_d;
    end
  end

  always_ff @(posedge clock) begin
    a_q   <= a_d;
    b_q   <= b_d;
    p_q   <= p_d;
    rem_q <= rem_d;
    quo_q <= quo_d;
  end

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == FIN);
  assign result    = result_q;
  assign remainder = remainder_q;
  assign remain    = remain_q;
  assign divzero   = divzero_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq at WIDTH=11: handshake timing, arithmetic results,
// divide corner cases, ignored strobes while busy and reset mid-operation.
module tb_alu_seq;
  timeunit 1ns;
  timeprecision 1ps;

  localparam int WIDTH = 11;
  localparam int RW    = 2 * WIDTH;
  localparam int LAT   = WIDTH + 1;

  logic                    clock = 1'b0;
  logic                    reset = 1'b1;
  logic                    computestrobe = 1'b0;
  logic [1:0]              opcode = 2'b00;
  logic signed [WIDTH-1:0] regA = '0;
  logic signed [WIDTH-1:0] regB = '0;
  logic                    busy, done, remain, divzero;
  logic signed [RW-1:0]    result;
  logic [WIDTH-1:0]        remainder;

  int n_pass = 0;
  int n_total = 0;

  alu_seq #(.WIDTH(WIDTH)) dut (
    .clock         (clock),
    .reset         (reset),
    .computestrobe (computestrobe),
    .opcode        (opcode),
    .regA          (regA),
    .regB          (regB),
    .busy          (busy),
    .done          (done),
    .result        (result),
    .remainder     (remainder),
    .remain        (remain),
    .divzero       (divzero)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Accept on the next edge (cycle 0), then walk cycles 1..ncyc checking busy and the done pulse.
  task automatic run_op(input logic [1:0] op, input int a, input int b, input int ncyc,
                        input int done_at, input int pulse_at, input string tag);
    logic [31:0] av, bv;
    av = a;
    bv = b;
    opcode = op;
    regA = av[WIDTH-1:0];
    regB = bv[WIDTH-1:0];
    computestrobe = 1'b1;
    step();
    computestrobe = 1'b0;
    for (int c = 1; c <= ncyc; c++) begin
      chk({tag, " busy"}, longint'(busy), 1);
      chk({tag, " done"}, longint'(done), longint'(c == done_at));
      if (c == pulse_at) begin
        computestrobe = 1'b1;
        opcode = 2'b00;
        regA = 11'sd1;
        regB = 11'sd1;
      end
      if (c < ncyc) begin
        step();
        computestrobe = 1'b0;
      end
    end
  endtask

  task automatic chk_out(input string tag, input longint r, input longint rem,
                         input longint rm, input longint dz);
    chk({tag, " result"}, longint'(result), r);
    chk({tag, " remainder"}, longint'(remainder), rem);
    chk({tag, " remain"}, longint'(remain), rm);
    chk({tag, " divzero"}, longint'(divzero), dz);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected $finish");
    $fatal(1, "bench timed out");
  end

  initial begin
    step();
    step();
    chk("reset busy", longint'(busy), 0);
    chk("reset done", longint'(done), 0);
    chk_out("reset", 0, 0, 0, 0);
    reset = 1'b0;
    step();

    run_op(2'b00, 999, 999, 1, 1, 0, "add");
    chk_out("add", 1998, 0, 0, 0);
    step();
    chk("add idle busy", longint'(busy), 0);
    chk("add idle done", longint'(done), 0);
    chk("add hold", longint'(result), 1998);

    run_op(2'b01, -999, 999, 1, 1, 0, "sub");
    chk_out("sub", -1998, 0, 0, 0);
    step();

    run_op(2'b10, 999, -999, LAT, LAT, 0, "mul");
    chk_out("mul", -998001, 0, 0, 0);
    step();
    chk("mul idle busy", longint'(busy), 0);

    run_op(2'b10, -1024, -1024, LAT, LAT, 5, "mul min");
    chk_out("mul min", 1048576, 0, 0, 0);
    step();
    chk("mul min strobe ignored busy", longint'(busy), 0);

    run_op(2'b11, -7, 2, LAT, LAT, 0, "div -7/2");
    chk_out("div -7/2", -4, 1, 1, 0);
    step();

    run_op(2'b11, -7, -2, LAT, LAT, 0, "div -7/-2");
    chk_out("div -7/-2", 4, 1, 1, 0);
    step();

    run_op(2'b11, 6, 3, LAT, LAT, 0, "div 6/3");
    chk_out("div 6/3", 2, 0, 0, 0);
    step();

    run_op(2'b11, 5, 0, 1, 1, 0, "div 5/0");
    chk_out("div 5/0", 0, 0, 0, 1);
    step();

    run_op(2'b00, 1, 1, 1, 1, 0, "add after div0");
    chk_out("add after div0", 2, 0, 0, 0);
    step();

    run_op(2'b11, 100, 7, 6, 0, 0, "div reset");
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("post-reset busy", longint'(busy), 0);
    chk("post-reset done", longint'(done), 0);
    chk_out("post-reset", 0, 0, 0, 0);
    for (int c = 0; c < 10; c++) begin
      chk("no done after reset", longint'(done), 0);
      step();
    end

    run_op(2'b00, 3, 4, 1, 1, 0, "add after reset");
    chk_out("add after reset", 7, 0, 0, 0);
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
